// File: rtl/conv_window_fetch.sv
// Streams KxK stride-1 windows from the image buffer to the MAC array.
// Define WINDOW_REUSE_EN to shift windows and fetch only the new column.
module conv_window_fetch #(
  parameter int DATA_SIZE      = 16,
  parameter int K              = 5,
  parameter int ADDR_W         = 10,
  parameter int IMG_SIZE_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [IMG_SIZE_WIDTH-1:0]   img_size,
  input  logic [ADDR_W-1:0]           base_addr,
  output logic                        rd_en,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic [DATA_SIZE-1:0]        rd_data,
  output logic [K*K*DATA_SIZE-1:0]    win,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [IMG_SIZE_WIDTH-1:0]   out_row,
  output logic [IMG_SIZE_WIDTH-1:0]   out_col,
  output logic                        busy,
  output logic                        done
);

  localparam int IW = IMG_SIZE_WIDTH;
  localparam int AW = 2 * IW + 2;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int WW = K * K * DATA_SIZE;
  localparam logic [KW-1:0] KM1 = KW'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] n_q, n_d;
  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [KW-1:0] ir_q, ir_d;
  logic [KW-1:0] ic_q, ic_d;
  logic iss_done_q, iss_done_d;
  logic part_q, part_d;
  logic pend_q, pend_d;
  logic [KW-1:0] pr_q, pr_d;
  logic [KW-1:0] pc_q, pc_d;
  logic [WW-1:0] win_q, win_d;

  logic issue;
  logic [IW-1:0] lim;
  logic [AW-1:0] addr_full;
  logic unused_hi;
  int wslot;

  assign issue = (state_q == S_FETCH) && !iss_done_q;
  assign lim   = n_q - IW'(K);
  assign wslot = int'(pr_q) * K + int'(pc_q);

  assign addr_full = AW'(base_q)
                   + (AW'(row_q) + AW'(ir_q)) * AW'(n_q)
                   + AW'(col_q) + AW'(ic_q);
  assign unused_hi = ^addr_full[AW-1:ADDR_W];

  assign rd_en     = issue;
  assign rd_addr   = issue ? addr_full[ADDR_W-1:0] : '0;
  assign win       = win_q;
  assign win_valid = (state_q == S_EMIT);
  assign busy      = (state_q == S_FETCH) || (state_q == S_EMIT);
  assign done      = (state_q == S_DONE);
  assign out_row   = row_q;
  assign out_col   = col_q;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    row_d      = row_q;
    col_d      = col_q;
    base_d     = base_q;
    ir_d       = ir_q;
    ic_d       = ic_q;
    iss_done_d = iss_done_q;
    part_d     = part_q;
    pend_d     = issue;
    pr_d       = ir_q;
    pc_d       = ic_q;
    win_d      = win_q;

    if (pend_q) begin
      win_d[wslot*DATA_SIZE +: DATA_SIZE] = rd_data;
    end

    // partial fetches walk rows only, pinned to the rightmost column
    if (issue) begin
      if (ir_q == KM1 && (part_q || ic_q == KM1)) begin
        iss_done_d = 1'b1;
      end else if (part_q || ic_q == KM1) begin
        ir_d = ir_q + 1'b1;
        ic_d = part_q ? KM1 : '0;
      end else begin
        ic_d = ic_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d    = img_size;
          base_d = base_addr;
          if (img_size < IW'(K)) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_FETCH;
            row_d      = '0;
            col_d      = '0;
            ir_d       = '0;
            ic_d       = '0;
            iss_done_d = 1'b0;
            part_d     = 1'b0;
          end
        end
      end
      S_FETCH: begin
        if (pend_q && pr_q == KM1 && pc_q == KM1) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (win_ready) begin
          if (col_q == lim && row_q == lim) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_FETCH;
            iss_done_d = 1'b0;
            ir_d       = '0;
            if (col_q == lim) begin
              col_d  = '0;
              row_d  = row_q + 1'b1;
              ic_d   = '0;
              part_d = 1'b0;
            end else begin
              col_d = col_q + 1'b1;
`ifdef WINDOW_REUSE_EN
              ic_d   = KM1;
              part_d = 1'b1;
              for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                  win_d[(r*K+c)*DATA_SIZE +: DATA_SIZE] =
                    win_q[(r*K+c+1)*DATA_SIZE +: DATA_SIZE];
                end
              end
`else
              ic_d   = '0;
              part_d = 1'b0;
`endif
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      base_q     <= '0;
      ir_q       <= '0;
      ic_q       <= '0;
      iss_done_q <= 1'b0;
      part_q     <= 1'b0;
      pend_q     <= 1'b0;
      pr_q       <= '0;
      pc_q       <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      row_q      <= row_d;
      col_q      <= col_d;
      base_q     <= base_d;
      ir_q       <= ir_d;
      ic_q       <= ic_d;
      iss_done_q <= iss_done_d;
      part_q     <= part_d;
      pend_q     <= pend_d;
      pr_q       <= pr_d;
      pc_q       <= pc_d;
      win_q      <= win_d;
    end
  end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Directed bench for conv_window_fetch with a mem[a]=a image buffer.
// Expected read counts follow WINDOW_REUSE_EN.
module tb_conv_window_fetch;

  localparam int K  = 5;
  localparam int DS = 16;
  localparam int WW = K * K * DS;
`ifdef WINDOW_REUSE_EN
  localparam int EXP6 = 60;
  localparam int EXP8 = 160;
`else
  localparam int EXP6 = 100;
  localparam int EXP8 = 400;
`endif

  logic clk;
  logic rst;
  logic start;
  logic [5:0] img_size;
  logic [9:0] base_addr;
  logic rd_en;
  logic [9:0] rd_addr;
  logic [15:0] rd_data;
  logic [WW-1:0] win;
  logic win_valid;
  logic win_ready;
  logic [5:0] out_row;
  logic [5:0] out_col;
  logic busy;
  logic done;

  int total = 0;
  int bad = 0;

  logic [15:0] mem [1024];

  conv_window_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .img_size  (img_size),
    .base_addr (base_addr),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .win       (win),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
    rd_data = '0;
  end

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string tag, input logic [WW-1:0] obs,
                     input logic [WW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] elem(input logic [WW-1:0] w,
                                       input int r, input int c);
    return w[(r*K+c)*DS +: DS];
  endfunction

  function automatic logic [WW-1:0] model_win(input int n, input int base,
                                              input int wr, input int wc);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DS +: DS] = 16'((base + (wr + r) * n + wc + c) % 1024);
    return w;
  endfunction

  task automatic run_pass(input int n, input int base, input int hold_idx,
                          input int poke, output int reads,
                          output logic [WW-1:0] w0,
                          output logic [WW-1:0] wl);
    int cyc, widx, first_rd, first_v, hs_cyc, last_hs, nw, m;
    logic prev_v;
    logic [WW-1:0] hw;
    logic [5:0] hr, hc;
    m  = n - K + 1;
    nw = m * m;
    @(negedge clk);
    start = 1'b1;
    img_size = 6'(n);
    base_addr = 10'(base);
    win_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; widx = 0; reads = 0; first_rd = -1; first_v = -1;
    hs_cyc = -1; last_hs = -1; prev_v = 1'b0; w0 = '0; wl = '0;
    while (!done && cyc < 4000) begin
      if (cyc == poke) begin
        start = 1'b1;
        img_size = 6'd4;
      end else if (cyc == poke + 1) begin
        start = 1'b0;
        img_size = 6'(n);
      end
      if (rd_en) begin
        reads++;
        if (first_rd < 0) begin
          first_rd = cyc;
          chk("first_addr", rd_addr, base);
        end
      end
      if (cyc == hs_cyc + 1) chk("resume", {rd_en, win_valid}, 2'b10);
      if (win_valid && !prev_v) begin
        if (first_v < 0) first_v = cyc;
        chk("pos", {out_row, out_col}, {6'(widx / m), 6'(widx % m)});
        chk("win", win, model_win(n, base, widx / m, widx % m));
        if (widx == 0) w0 = win;
        wl = win;
        if (widx == hold_idx) begin
          win_ready = 1'b0;
          hw = win;
          hr = out_row;
          hc = out_col;
          repeat (10) begin
            @(negedge clk);
            cyc++;
            if (rd_en) reads++;
            chk("hold_win", win, hw);
            chk("hold_st", {rd_en, win_valid, out_row, out_col},
                {2'b01, hr, hc});
          end
          win_ready = 1'b1;
          hs_cyc = cyc;
        end
        widx++;
      end
      if (win_valid && win_ready) last_hs = cyc;
      prev_v = win_valid;
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done, 1);
    chk("done_cyc", cyc, last_hs + 1);
    chk("busy_end", busy, 0);
    chk("nwin", widx, nw);
    chk("first_rd", first_rd, 1);
    chk("first_v", first_v, K * K + 2);
  endtask

  initial begin
    int reads, cnt;
    logic [WW-1:0] w0, wl;
    rst = 1'b1;
    start = 1'b0;
    img_size = '0;
    base_addr = '0;
    win_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", {rd_en, rd_addr, win_valid, out_row, out_col, busy, done}, 0);
    chk("rst_win", win, 0);
    rst = 1'b0;

    run_pass(6, 0, -1, -1, reads, w0, wl);
    chk("r6_reads", reads, EXP6);
    chk("w00_e00", elem(w0, 0, 0), 0);
    chk("w00_e44", elem(w0, 4, 4), 28);
    chk("w11_e00", elem(wl, 0, 0), 7);
    chk("w11_e44", elem(wl, 4, 4), 35);

    run_pass(6, 0, 1, 5, reads, w0, wl);
    chk("bp_reads", reads, EXP6);
    chk("bp_w11_e44", elem(wl, 4, 4), 35);

    @(negedge clk);
    start = 1'b1;
    img_size = 6'd4;
    base_addr = '0;
    @(negedge clk);
    start = 1'b0;
    chk("small_done", {done, busy}, 2'b10);
    cnt = 0;
    repeat (20) begin
      if (rd_en || win_valid) cnt++;
      @(negedge clk);
    end
    chk("small_quiet", cnt, 0);

    run_pass(8, 1000, -1, -1, reads, w0, wl);
    chk("r8_reads", reads, EXP8);
    chk("wrap_e00", elem(w0, 0, 0), 1000);
    chk("wrap_e44", elem(w0, 4, 4), 12);

    @(negedge clk);
    start = 1'b1;
    img_size = 6'd6;
    base_addr = '0;
    win_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!(out_row == 6'd1 && rd_en) && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    chk("reach_r1", {out_row, rd_en}, {6'd1, 1'b1});
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst", {rd_en, rd_addr, win_valid, out_row, out_col, busy, done}, 0);
    chk("mid_rst_win", win, 0);
    rst = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (rd_en) cnt++;
    end
    chk("post_rst_quiet", cnt, 0);

    run_pass(6, 0, -1, -1, reads, w0, wl);
    chk("re_w00_e44", elem(w0, 4, 4), 28);
    chk("re_w11_e00", elem(wl, 0, 0), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_window_fetch.md
# conv_window_fetch

Streams K×K convolution windows out of the on-chip image buffer that the image loader fills, one output position at a time in row-major order. It sits between the image loader, which writes the buffer and raises done, and the convolution MAC array, which consumes one window per valid/ready handshake. Stride is 1 with no padding. An N×N image yields (N−K+1)² windows.

## Interface
- DATA_SIZE, 16, pixel width (fixed-point)
- K, 5, window edge
- ADDR_W, 10, image buffer address width (1024 words)
- IMG_SIZE_WIDTH, 6, width of image-size input
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a pass; sampled only in IDLE
- img_size  in  IMG_SIZE_WIDTH  image edge N; sampled with start
- base_addr  in  ADDR_W  buffer address of pixel (0,0); sampled with start
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_W  buffer read address
- rd_data  in  DATA_SIZE  read data, valid exactly 1 cycle after rd_en
- win  out  K*K*DATA_SIZE  window; element (r,c) at bits [(r*K+c)*DATA_SIZE +: DATA_SIZE]
- win_valid  out  1  window valid
- win_ready  in  1  consumer accepts
- out_row, out_col  out  IMG_SIZE_WIDTH  output position of current window
- busy  out  1  high outside IDLE/DONE
- done  out  1  level; high in DONE, cleared by next accepted start

## Operation
- States: IDLE → FETCH → EMIT → (FETCH | DONE); DONE → FETCH or DONE on start.
- IDLE/DONE: start=1 latches img_size and base_addr and clears done.
  - If img_size < K: go to DONE, issue no reads.
  - Else: set out_row=out_col=0 and enter FETCH.
- FETCH, full mode: issue K*K reads, one per cycle, r outer and c inner. rd_addr = base_addr + (out_row+r)*img_size + (out_col+c), modulo 2^ADDR_W.
  - Each returning rd_data is written into its window slot.
  - After the last slot is written, go to EMIT.
- EMIT: win_valid=1. win, out_row and out_col are held stable until win_valid && win_ready.
  - On handshake, advance out_col.
  - At out_col = N−K, wrap out_col to 0 and increment out_row.
  - After position (N−K, N−K): go to DONE.
  - Otherwise: go to FETCH.
- start while busy is ignored. win_ready outside EMIT is ignored.
- Address arithmetic uses at least 2*IMG_SIZE_WIDTH+1 bits internally, then truncates to ADDR_W.
- rst in any state, including mid-fetch:
  - Next cycle is IDLE. No rd_en is issued after rst.
  - In-flight rd_data is discarded.

## Timing
- Reset values: rd_en=0, rd_addr=0, win=0, win_valid=0, out_row=0, out_col=0, busy=0, done=0.
- Start accepted at cycle 0:
  - rd_en is high cycles 1..K*K.
  - Data is sampled cycles 2..K*K+1.
  - win_valid rises at cycle K*K+2.
- Handshake at cycle t: next-window reads start at t+1, and win_valid drops at t+1.
- Final handshake at cycle t: done=1 and busy=0 from t+1.
- img_size < K with start at cycle 0: done=1 at cycle 1.

## Configuration
- WINDOW_REUSE_EN defined:
  - When out_col advances within a row, the window shifts left by one column.
  - Only the new right column is fetched: K reads, r=0..K−1, at column out_col+K−1. win_valid follows K+2 cycles after the handshake.
  - Row starts still do a full K*K fetch.
- Undefined: every window is a full K*K fetch.
- win contents, address values and emission order are identical in both builds; only read count and latency differ.

## Test plan
- Buffer mem[a]=a, base_addr=0, img_size=6, K=5, win_ready=1 → 4 windows, in order (0,0),(0,1),(1,0),(1,1).
  - Window (0,0): element (0,0)=0, element (4,4)=28.
  - Window (1,1): element (0,0)=7, element (4,4)=35.
  - done=1 the cycle after the 4th handshake.
- Same setup, start at cycle 0 → first rd_en at cycle 1 with rd_addr=0, win_valid at cycle 27.
- Backpressure: hold win_ready=0 for 10 cycles on window (0,1) → win and position stable, no rd_en during the hold.
  - Next reads begin the cycle after win_ready rises.
- img_size=4 → zero rd_en pulses, done=1 at cycle 1, win_valid never asserted. start during busy ignored.
- img_size=8, base_addr=1000 → address wrap: window (0,0) element (0,0) reads address 1000, element (4,4) reads (1000+36) mod 1024 = 12.
  - Total rd_en count: 400 without WINDOW_REUSE_EN, 160 with it.
- rst asserted during FETCH of window (1,0) → next cycle all outputs at reset values, no rd_en.
  - A new start then produces window (0,0) correctly.
